vga_fb_scheduler: RTL and testbench
===================================

Name: vga_fb_scheduler

Overview:
- Frame-buffer scan-out controller for the VGA output path.
- Generates its own 768-clock line and 512-line frame timing.
- Fetches 8-pixel words from a single-port pixel RAM at fixed slots and serialises them onto R/G/B.
- Arbitrates all remaining RAM cycles to a writer (CPU/drawing engine) through a valid/ready handshake.

Parameters:
- H_TOTAL, 768: clocks per line; X counter wraps H_TOTAL-1 -> 0.
- H_SYNC, 16: hsync active while X < H_SYNC.
- H_START, 128: first active X; must be a multiple of 8 and >= 8.
- H_ACTIVE, 512: active pixels per line; multiple of 8.
- V_TOTAL, 512: lines per frame.
- V_SYNC, 1: vsync active while Y < V_SYNC.
- V_START, 16: first active line.
- V_ACTIVE, 480: active lines.
- ADDR_W, 15: RAM word address width (64 words/line x 480 lines).

Ports:
- clk  in  1  system clock
- Rst  in  1  asynchronous active-high reset
- wr_valid  in  1  writer request
- wr_ready  out  1  writer may transfer this cycle
- wr_addr  in  ADDR_W  writer word address
- wr_data  in  24  writer word: 8 pixels x {R,G,B}; pixel 0 = bits [2:0], bit0 = B, bit1 = G, bit2 = R
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable (qualifies mem_en)
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  24  RAM write data
- mem_rdata  in  24  RAM read data, valid one cycle after a read strobe
- vga_h_sync  out  1  active-low hsync
- vga_v_sync  out  1  active-low vsync
- R, G, B  out  1 each  pixel colour
- frame_start  out  1  one-cycle pulse, registered from X==0 && Y==0

Behaviour:
- Reset (async, any time, including mid-line or mid-write):
  - X, Y, fetch address, hold and shift registers <= 0.
  - vga_h_sync = vga_v_sync = 1; R = G = B = 0; frame_start = 0.
  - mem_en = mem_we = 0 and wr_ready = 0 while Rst is high.
  - An interrupted write is not retried. After release, timing restarts at X = 0, Y = 0.
- Counters:
  - X increments every clock and wraps at H_TOTAL-1.
  - Y increments when X wraps and itself wraps at V_TOTAL-1 -> 0.
- Active region: line_act = (V_START <= Y < V_START+V_ACTIVE); pix_act = line_act && (H_START <= X < H_START+H_ACTIVE).
- Fetch slots:
  - Occur when line_act && X[2:0]==0 && H_START-8 <= X < H_START+H_ACTIVE-8, giving H_ACTIVE/8 slots per active line.
  - In a slot: mem_en = 1, mem_we = 0, mem_addr = fetch address.
  - Fetch address increments after each slot and clears to 0 when X==0 && Y==0, so row r, word k maps to address r*64 + k without a multiplier.
- Read return:
  - mem_rdata is captured into a hold register on the cycle after a slot.
  - When pix_act && X[2:0]==0, the hold register loads into the 24-bit shift register.
  - On every other active cycle the shift register shifts right by 3.
- Pixel output:
  - R/G/B are registered from shift[2:0] gated by pix_act, else 0.
  - Pixel column p is therefore visible while X == H_START+p+1.
- Syncs: registered, vga_h_sync = ~(X < H_SYNC) and vga_v_sync = ~(Y < V_SYNC), giving the same one-clock delay as the pixels.
- Writer arbitration:
  - The display has absolute priority.
  - wr_ready = ~slot && ~Rst, combinational from the counters only; it never depends on wr_valid.
  - Transfer occurs when wr_valid && wr_ready: mem_en = mem_we = 1, mem_addr = wr_addr, mem_wdata = wr_data, all in the same cycle.
  - During a slot, wr_valid is ignored and the writer must hold its request.
  - Outside active lines, every cycle is available to the writer.
- When no access is made: mem_en = 0, mem_we = 0, mem_wdata = 0.
- A write to the word currently being displayed takes effect only if it lands before that word's slot; no bypass is provided.

Test Plan:
- Reset release, no writes, RAM preloaded with word n = n:
  - vga_h_sync low exactly 16 clocks per 768.
  - vga_v_sync low for exactly the one line with Y=0 (768 clocks) per frame.
  - frame_start pulses once every 393216 clocks.
- RAM word 0 = 24'h FAC688 (pixels 0..7 = 0,1,2,3,4,5,6,7):
  - On line Y=16, R/G/B at X=129..136 follow the values 0..7.
  - All outputs are 0 at X=128 and at X=641.
- wr_valid held high continuously during line Y=20:
  - wr_ready is low exactly at X = 120, 128, ..., 624 (64 cycles).
  - mem_we never coincides with a fetch.
  - 704 writes complete on that line; 768 complete on line Y=500.
- Write word 64 = 24'h FFFFFF during line Y=16 before X=120:
  - Line Y=17 displays white at X=129..136.
  - Line Y=16 display is unaffected.
- Assert Rst for 3 clocks at X=300, Y=200 while a write is pending:
  - All outputs go to their reset values within the same cycle.
  - No mem_en while Rst is high.
  - After release, the next frame_start occurs at X=0, Y=0 and fetch addresses restart at 0.
- Writer to address 30719 at Y=495 (final active row):
  - The write is accepted.
  - The fetch address wraps to 0 at the following frame start.

Source files
------------

// File: rtl/vga_fb_scheduler.sv
// VGA frame-buffer scan-out: self-timed raster, fixed-slot 8-pixel fetches
// from a single-port RAM, and leftover RAM cycles granted to a writer.
module vga_fb_scheduler #(
  parameter int unsigned H_TOTAL  = 768,
  parameter int unsigned H_SYNC   = 16,
  parameter int unsigned H_START  = 128,
  parameter int unsigned H_ACTIVE = 512,
  parameter int unsigned V_TOTAL  = 512,
  parameter int unsigned V_SYNC   = 1,
  parameter int unsigned V_START  = 16,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned ADDR_W   = 15
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [23:0]       mem_wdata,
  input  logic [23:0]       mem_rdata,
  output logic              vga_h_sync,
  output logic              vga_v_sync,
  output logic              R,
  output logic              G,
  output logic              B,
  output logic              frame_start
);

  localparam int unsigned XW = $clog2(H_TOTAL + 1);
  localparam int unsigned YW = $clog2(V_TOTAL + 1);

  localparam logic [XW-1:0] X_LAST     = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_SYNC     = XW'(H_SYNC);
  localparam logic [XW-1:0] X_FETCH0   = XW'(H_START - 8);
  localparam logic [XW-1:0] X_FETCH_E  = XW'(H_START + H_ACTIVE - 8);
  localparam logic [XW-1:0] X_ACT0     = XW'(H_START);
  localparam logic [XW-1:0] X_ACT_E    = XW'(H_START + H_ACTIVE);
  localparam logic [YW-1:0] Y_LAST     = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_SYNC     = YW'(V_SYNC);
  localparam logic [YW-1:0] Y_ACT0     = YW'(V_START);
  localparam logic [YW-1:0] Y_ACT_E    = YW'(V_START + V_ACTIVE);

  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [ADDR_W-1:0] r_fetch_addr;
  logic [23:0]       r_hold;
  logic [23:0]       r_shift;
  logic              r_slot_d;
  logic [2:0]        r_rgb;
  logic              r_hsync;
  logic              r_vsync;
  logic              r_frame_start;

  logic              w_line_act;
  logic              w_pix_act;
  logic              w_slot;
  logic              w_frame0;
  logic              w_xfer;
  logic [23:0]       w_shift_next;

  always_comb begin
    w_line_act = (r_y >= Y_ACT0) && (r_y < Y_ACT_E);
    w_pix_act  = w_line_act && (r_x >= X_ACT0) && (r_x < X_ACT_E);
    w_slot     = w_line_act && (r_x[2:0] == 3'd0) &&
                 (r_x >= X_FETCH0) && (r_x < X_FETCH_E);
    w_frame0   = (r_x == '0) && (r_y == '0);
  end

  // Display has absolute priority; the grant never looks at wr_valid.
  always_comb begin
    wr_ready  = ~w_slot & ~Rst;
    w_xfer    = wr_valid & wr_ready;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!Rst) begin
      if (w_slot) begin
        mem_en   = 1'b1;
        mem_addr = r_fetch_addr;
      end else if (w_xfer) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
      end
    end
  end

  // RGB samples the post-load shift value so pixel p shows at X = H_START+p+1.
  always_comb begin
    w_shift_next = r_shift;
    if (w_pix_act) begin
      if (r_x[2:0] == 3'd0) w_shift_next = r_hold;
      else                  w_shift_next = {3'b000, r_shift[23:3]};
    end
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_x           <= '0;
      r_y           <= '0;
      r_fetch_addr  <= '0;
      r_hold        <= '0;
      r_shift       <= '0;
      r_slot_d      <= 1'b0;
      r_rgb         <= '0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      if (r_x == X_LAST) begin
        r_x <= '0;
        if (r_y == Y_LAST) r_y <= '0;
        else               r_y <= r_y + YW'(1);
      end else begin
        r_x <= r_x + XW'(1);
      end
      if (w_frame0)    r_fetch_addr <= '0;
      else if (w_slot) r_fetch_addr <= r_fetch_addr + ADDR_W'(1);
      r_slot_d <= w_slot;
      if (r_slot_d) r_hold <= mem_rdata;
      r_shift       <= w_shift_next;
      r_rgb         <= w_pix_act ? w_shift_next[2:0] : 3'b000;
      r_hsync       <= ~(r_x < X_SYNC);
      r_vsync       <= ~(r_y < Y_SYNC);
      r_frame_start <= w_frame0;
    end
  end

  assign vga_h_sync  = r_hsync;
  assign vga_v_sync  = r_vsync;
  assign R           = r_rgb[2];
  assign G           = r_rgb[1];
  assign B           = r_rgb[0];
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Bench for vga_fb_scheduler on a reduced raster: timing model, RAM model,
// and a pixel scoreboard filled at fetch slots and drained at visible pixels.
module tb_vga_fb_scheduler;

  localparam int unsigned H_TOTAL  = 96;
  localparam int unsigned H_SYNC   = 4;
  localparam int unsigned H_START  = 16;
  localparam int unsigned H_ACTIVE = 64;
  localparam int unsigned V_TOTAL  = 32;
  localparam int unsigned V_SYNC   = 1;
  localparam int unsigned V_START  = 4;
  localparam int unsigned V_ACTIVE = 24;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned WPL      = H_ACTIVE / 8;
  localparam int unsigned WORDS    = V_ACTIVE * WPL;
  localparam int unsigned FRAME    = H_TOTAL * V_TOTAL;

  logic              clk = 1'b0;
  logic              Rst = 1'b0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [23:0]       wr_data = '0;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [23:0]       mem_wdata;
  logic [23:0]       mem_rdata = '0;
  logic              vga_h_sync, vga_v_sync, R, G, B, frame_start;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned mx = 0, my = 0;

  logic [23:0] ram    [0:(1<<ADDR_W)-1];
  logic [23:0] refmem [0:(1<<ADDR_W)-1];
  logic [2:0]  sb_q [$];

  vga_fb_scheduler #(
    .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_START(H_START), .H_ACTIVE(H_ACTIVE),
    .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_START(V_START), .V_ACTIVE(V_ACTIVE),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .Rst(Rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync), .R(R), .G(G), .B(B),
    .frame_start(frame_start)
  );

  initial forever #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (x=%0d y=%0d t=%0t)", tag, got, exp, mx, my, $time);
    end
  endtask

  // Single-port RAM with one-cycle read latency.
  initial begin
    for (int unsigned i = 0; i < (1<<ADDR_W); i++) ram[i] = 24'(i);
    ram[0] = 24'hFAC688;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        else        mem_rdata <= ram[mem_addr];
      end
    end
  end

  // Raster position of the current cycle.
  initial forever begin
    @(posedge clk);
    if (Rst) begin
      mx = 0; my = 0;
    end else if (mx == H_TOTAL-1) begin
      mx = 0;
      my = (my == V_TOTAL-1) ? 0 : my + 1;
    end else begin
      mx = mx + 1;
    end
  end

  // Per-cycle monitor: expected combinational outputs from this cycle,
  // registered outputs from the previous one.
  initial begin
    bit p_valid, p_hs, p_vs, p_fs, p_pix;
    bit la, slot, pix, xfer, hline_ok, vframe_ok;
    int unsigned fa, hs_low, vs_low, fs_cnt, qs;
    logic [23:0] w;
    logic [2:0]  e;
    for (int unsigned i = 0; i < (1<<ADDR_W); i++) refmem[i] = 24'(i);
    refmem[0] = 24'hFAC688;
    p_valid = 0; hline_ok = 0; vframe_ok = 0; hs_low = 0; vs_low = 0; fs_cnt = 0;
    forever begin
      @(negedge clk);
      if (Rst) begin
        check_eq("rst_mem_en", mem_en, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_wr_ready", wr_ready, 0);
        check_eq("rst_hsync", vga_h_sync, 1);
        check_eq("rst_vsync", vga_v_sync, 1);
        check_eq("rst_rgb", {R, G, B}, 0);
        check_eq("rst_fs", frame_start, 0);
        sb_q.delete();
        p_valid = 0; hline_ok = 0; vframe_ok = 0;
        continue;
      end
      la   = (my >= V_START) && (my < V_START + V_ACTIVE);
      slot = la && (mx % 8 == 0) && (mx >= H_START - 8) && (mx < H_START + H_ACTIVE - 8);
      pix  = la && (mx >= H_START) && (mx < H_START + H_ACTIVE);
      fa   = (my - V_START) * WPL + (mx - (H_START - 8)) / 8;
      xfer = wr_valid && !slot;

      check_eq("wr_ready", wr_ready, !slot);
      check_eq("mem_en", mem_en, slot || xfer);
      check_eq("mem_we", mem_we, xfer);
      check_eq("mem_wdata", mem_wdata, xfer ? wr_data : 24'h0);
      if (slot)      check_eq("fetch_addr", mem_addr, fa);
      else if (xfer) check_eq("wr_addr_out", mem_addr, wr_addr);

      check_eq("hsync", vga_h_sync, p_valid ? !p_hs : 1'b1);
      check_eq("vsync", vga_v_sync, p_valid ? !p_vs : 1'b1);
      check_eq("frame_start", frame_start, p_valid && p_fs);
      if (p_valid && p_pix) begin
        qs = sb_q.size();
        if (qs == 0) check_eq("sb_underflow", qs, 1);
        else begin
          e = sb_q.pop_front();
          check_eq("pixel", {R, G, B}, e);
        end
      end else begin
        check_eq("blank", {R, G, B}, 0);
      end

      if (slot) begin
        w = refmem[fa];
        for (int unsigned k = 0; k < 8; k++) sb_q.push_back(w[3*k +: 3]);
      end
      if (xfer) refmem[wr_addr] = wr_data;

      if (mx == 0) begin
        if (hline_ok) check_eq("hs_low_per_line", hs_low, H_SYNC);
        hs_low = 0; hline_ok = 1;
        if (my == 0) begin
          if (vframe_ok) begin
            check_eq("vs_low_per_frame", vs_low, H_TOTAL);
            check_eq("fs_per_frame", fs_cnt, 1);
          end
          vs_low = 0; fs_cnt = 0; vframe_ok = 1;
        end
      end
      if (!vga_h_sync) hs_low++;
      if (!vga_v_sync) vs_low++;
      if (frame_start) fs_cnt++;

      p_valid = 1; p_hs = (mx < H_SYNC); p_vs = (my < V_SYNC);
      p_fs = (mx == 0 && my == 0); p_pix = pix;
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_pos(input int unsigned x, input int unsigned y);
    bit found = 0;
    for (int unsigned i = 0; i < 2*FRAME; i++) begin
      if (mx == x && my == y) begin found = 1; break; end
      step(1);
    end
    check_eq("wait_pos", found, 1);
  endtask

  task automatic full_line(input int unsigned y, input int unsigned exp_wr, input int unsigned exp_busy);
    int unsigned nw = 0, nb = 0;
    wait_pos(0, y);
    for (int unsigned i = 0; i < H_TOTAL; i++) begin
      wr_valid = 1'b1;
      wr_addr  = ADDR_W'($urandom_range(0, WORDS-1));
      wr_data  = 24'($urandom);
      @(negedge clk);
      if (mem_en && mem_we) nw++;
      if (!wr_ready) nb++;
      step(1);
    end
    wr_valid = 1'b0;
    check_eq("writes_per_line", nw, exp_wr);
    check_eq("busy_per_line", nb, exp_busy);
  endtask

  initial begin
    #1 Rst = 1'b1;
    step(3);
    Rst = 1'b0;

    // Word WPL (row 1, word 0) goes white before its slot; row 0 untouched.
    wait_pos(0, V_START);
    wr_valid = 1'b1; wr_addr = ADDR_W'(WPL); wr_data = 24'hFFFFFF;
    step(1);
    wr_valid = 1'b0;
    wait_pos(H_START, V_START);
    @(negedge clk); check_eq("px_before_active", {R, G, B}, 0);
    for (int unsigned i = 0; i < 8; i++) begin
      step(1);
      @(negedge clk); check_eq("px_row0", {R, G, B}, i);
    end
    wait_pos(H_START + H_ACTIVE + 1, V_START);
    @(negedge clk); check_eq("px_after_active", {R, G, B}, 0);
    wait_pos(H_START + 1, V_START + 1);
    for (int unsigned i = 0; i < 8; i++) begin
      @(negedge clk); check_eq("px_row1_white", {R, G, B}, 7);
      step(1);
    end

    full_line(V_START + 4, H_TOTAL - WPL, WPL);
    full_line(V_START + V_ACTIVE + 2, H_TOTAL, 0);

    // Last word of the final active row, then the fetch address must wrap.
    wait_pos(0, V_START + V_ACTIVE - 1);
    wr_valid = 1'b1; wr_addr = ADDR_W'(WORDS - 1); wr_data = 24'h5A5A5A;
    @(negedge clk);
    check_eq("last_wr_we", mem_we, 1);
    check_eq("last_wr_addr", mem_addr, WORDS - 1);
    step(1);
    wr_valid = 1'b0;
    wait_pos(H_START - 8, V_START);
    @(negedge clk);
    check_eq("wrap_en", mem_en, 1);
    check_eq("wrap_addr", mem_addr, 0);

    // Reset mid-line with a write pending.
    wait_pos(50, 20);
    wr_valid = 1'b1; wr_addr = 8'd3; wr_data = 24'h123456;
    Rst = 1'b1;
    step(3);
    Rst = 1'b0;
    wr_valid = 1'b0;
    @(negedge clk); check_eq("fs_after_rel0", frame_start, 0);
    step(1);
    @(negedge clk); check_eq("fs_after_rel1", frame_start, 1);
    wait_pos(H_START - 8, V_START);
    @(negedge clk);
    check_eq("restart_en", mem_en, 1);
    check_eq("restart_addr", mem_addr, 0);
    step(FRAME + 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
